// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with full-depth usage, occupancy count, threshold flags,
// a read-data-valid strobe and sticky overflow/underflow error flags.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_accept;
    logic              rd_accept;
    logic [ADDR_W:0]   count_w;

    // The extra wrap bit on each pointer lets full and empty be told apart with no lost slot.
    assign count_w = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_accept) begin
            rptr_d     = rptr_q + 1'b1;
            data_out_d = mem_q[rptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end

        // A new error in the same cycle as err_clr must survive the clear.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_w;
    assign almost_full  = (count_w >= AF_LVL);
    assign almost_empty = (count_w <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
